// File: rtl/fpu_pkg.sv
// Shared widths, limits and FSM encoding for the FPU result normalizer.
package fpu_pkg;

    localparam int unsigned EXP_W = 6;
    localparam int unsigned MAN_W = 22;
    localparam logic [EXP_W-1:0] EXP_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fpu_normalizer.sv
// Iterative one-bit-per-cycle normalizer for raw FPALU results, with
// carry, zero, denormal, overflow and inexact handling.
module fpu_normalizer
    import fpu_pkg::*;
#(
    parameter int unsigned NORM_BIT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_uni_sgn,
    input  logic [EXP_W-1:0] din_uni_exp,
    input  logic [MAN_W-1:0] din_uni_man_dn,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout_uni_sgn,
    output logic [EXP_W-1:0] dout_uni_exp,
    output logic [MAN_W-1:0] dout_uni_man,
    output logic             dout_zero,
    output logic             dout_denorm,
    output logic             dout_ovf,
    output logic             dout_inexact,
    output logic             dout_valid,
    input  logic             dout_ready
);

    state_e           state_q;
    logic             sgn_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W-1:0] man_q;
    logic             zero_q;
    logic             denorm_q;
    logic             ovf_q;
    logic             inexact_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sgn_q     <= 1'b0;
            exp_q     <= '0;
            man_q     <= '0;
            zero_q    <= 1'b0;
            denorm_q  <= 1'b0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        sgn_q     <= din_uni_sgn;
                        exp_q     <= din_uni_exp;
                        man_q     <= din_uni_man_dn;
                        zero_q    <= 1'b0;
                        denorm_q  <= 1'b0;
                        ovf_q     <= 1'b0;
                        inexact_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Priority order matters: carry before zero/normal tests,
                    // and the exp==0 test guards the left shift from wrapping.
                    if (man_q[MAN_W-1] && exp_q == EXP_MAX) begin
                        man_q   <= '0;
                        ovf_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (man_q[MAN_W-1]) begin
                        man_q     <= man_q >> 1;
                        exp_q     <= exp_q + EXP_W'(1);
                        inexact_q <= inexact_q | man_q[0];
                    end else if (man_q == '0) begin
                        exp_q   <= '0;
                        zero_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (man_q[NORM_BIT]) begin
                        state_q <= DONE;
                    end else if (exp_q == '0) begin
                        denorm_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        man_q <= man_q << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end
                end
                DONE: begin
                    if (dout_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign din_ready    = (state_q == IDLE);
    assign dout_valid   = (state_q == DONE);
    assign dout_uni_sgn = sgn_q;
    assign dout_uni_exp = exp_q;
    assign dout_uni_man = man_q;
    assign dout_zero    = zero_q;
    assign dout_denorm  = denorm_q;
    assign dout_ovf     = ovf_q;
    assign dout_inexact = inexact_q;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Randomized and directed bench for fpu_normalizer against a value-level
// reference model of the normalization rules.
module tb_fpu_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_uni_sgn;
    logic [5:0]  din_uni_exp;
    logic [21:0] din_uni_man_dn;
    logic        din_valid;
    logic        din_ready;
    logic        dout_uni_sgn;
    logic [5:0]  dout_uni_exp;
    logic [21:0] dout_uni_man;
    logic        dout_zero;
    logic        dout_denorm;
    logic        dout_ovf;
    logic        dout_inexact;
    logic        dout_valid;
    logic        dout_ready;

    int n_vec  = 0;
    int n_miss = 0;

    fpu_normalizer #(.NORM_BIT(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .din_uni_sgn    (din_uni_sgn),
        .din_uni_exp    (din_uni_exp),
        .din_uni_man_dn (din_uni_man_dn),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .dout_uni_sgn   (dout_uni_sgn),
        .dout_uni_exp   (dout_uni_exp),
        .dout_uni_man   (dout_uni_man),
        .dout_zero      (dout_zero),
        .dout_denorm    (dout_denorm),
        .dout_ovf       (dout_ovf),
        .dout_inexact   (dout_inexact),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [5:0]  e;
        logic [21:0] m;
        logic [3:0]  flags;   // {zero, denorm, ovf, inexact}
    } ref_t;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Latency counts edges from the transfer edge (=1) to the edge entering DONE.
    function automatic ref_t ref_model(input logic [5:0] e_in, input logic [21:0] m_in);
        ref_t   r;
        longint m;
        int     e;
        int     shifts;
        int     p;
        int     k;
        m = longint'(m_in);
        e = int'(e_in);
        shifts = 0;
        r.flags = 4'b0000;
        if (m >= 64'd2097152) begin
            if (e == 63) begin
                m = 0;
                r.flags[1] = 1'b1;
            end else begin
                r.flags[0] = (m % 2) != 0;
                m = m / 2;
                e = e + 1;
                shifts = 1;
            end
        end else if (m == 0) begin
            e = 0;
            r.flags[3] = 1'b1;
        end else begin
            p = 0;
            while ((m >> (p + 1)) != 0) p++;
            k = 20 - p;
            if (k > e) begin
                shifts = e;
                m = m * (64'd1 << e);
                e = 0;
                r.flags[2] = 1'b1;
            end else begin
                shifts = k;
                m = m * (64'd1 << k);
                e = e - k;
            end
        end
        r.lat = shifts + 2;
        r.e = 6'(e);
        r.m = 22'(m);
        return r;
    endfunction

    function automatic logic [39:0] pack_out();
        return 40'({dout_uni_sgn, dout_uni_exp, dout_uni_man,
                    dout_zero, dout_denorm, dout_ovf, dout_inexact});
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_vec(input logic s, input logic [5:0] e, input logic [21:0] m, input int hold);
        ref_t        r;
        int          n;
        logic [39:0] want;
        r = ref_model(e, m);
        want = 40'({s, r.e, r.m, r.flags});
        check_eq("din_ready_idle", 40'(din_ready), 40'd1);
        din_uni_sgn = s;
        din_uni_exp = e;
        din_uni_man_dn = m;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        din_uni_sgn = 1'($urandom);
        din_uni_exp = 6'($urandom);
        din_uni_man_dn = 22'($urandom);
        n = 1;
        while (dout_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq("latency", 40'(n), 40'(r.lat));
        check_eq("sgn", 40'(dout_uni_sgn), 40'(s));
        check_eq("exp", 40'(dout_uni_exp), 40'(r.e));
        check_eq("man", 40'(dout_uni_man), 40'(r.m));
        check_eq("flags", 40'({dout_zero, dout_denorm, dout_ovf, dout_inexact}), 40'(r.flags));
        check_eq("din_ready_done", 40'(din_ready), 40'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_valid", 40'(dout_valid), 40'd1);
            check_eq("stall_ready", 40'(din_ready), 40'd0);
            check_eq("stall_data", pack_out(), want);
        end
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        check_eq("retire_valid", 40'(dout_valid), 40'd0);
        check_eq("retire_ready", 40'(din_ready), 40'd1);
    endtask

    initial begin
        logic        seen;
        int          w;
        logic [21:0] mask;
        rst = 1'b1;
        din_valid = 1'b0;
        din_uni_sgn = 1'b0;
        din_uni_exp = '0;
        din_uni_man_dn = '0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_din_ready", 40'(din_ready), 40'd1);
        check_eq("reset_dout_valid", 40'(dout_valid), 40'd0);
        check_eq("reset_outputs", pack_out(), 40'd0);

        run_vec(1'b0, 6'd10, 22'h100000, 0);
        run_vec(1'b1, 6'd10, 22'h300001, 0);
        run_vec(1'b0, 6'd30, 22'h000001, 0);
        run_vec(1'b1, 6'd3,  22'h000100, 0);
        run_vec(1'b1, 6'd17, 22'h000000, 0);
        run_vec(1'b0, 6'd63, 22'h200000, 0);
        run_vec(1'b1, 6'd62, 22'h3FFFFF, 0);
        run_vec(1'b0, 6'd0,  22'h000001, 0);
        run_vec(1'b0, 6'd20, 22'h000001, 0);
        run_vec(1'b1, 6'd5,  22'h0ABCDE, 10);

        // Reset in the middle of a long left-shift sequence.
        din_uni_sgn = 1'b1;
        din_uni_exp = 6'd30;
        din_uni_man_dn = 22'h000001;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_din_ready", 40'(din_ready), 40'd1);
        check_eq("midrst_dout_valid", 40'(dout_valid), 40'd0);
        check_eq("midrst_outputs", pack_out(), 40'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        check_eq("midrst_no_output", 40'(seen), 40'd0);

        // Reset coinciding with a valid input must win.
        din_uni_sgn = 1'b1;
        din_uni_exp = 6'd40;
        din_uni_man_dn = 22'h100000;
        din_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        check_eq("rstprio_din_ready", 40'(din_ready), 40'd1);
        check_eq("rstprio_outputs", pack_out(), 40'd0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        check_eq("rstprio_no_output", 40'(seen), 40'd0);

        for (int v = 0; v < 200; v++) begin
            w = $urandom_range(0, 22);
            mask = (w == 0) ? 22'h0 : (22'h3FFFFF >> (22 - w));
            run_vec(1'($urandom), 6'($urandom), 22'($urandom) & mask, (v % 17 == 0) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fpu_normalizer.md
FPU_NORMALIZER -- requirements
Module: fpu_normalizer

Interface
REQ-001 SHALL have parameter NORM_BIT, default 20, mantissa bit that is 1 in a normalized result (bit 21 is carry headroom).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have ports din_uni_sgn (in, 1), din_uni_exp (in, 6), din_uni_man_dn (in, 22): raw FPALU result, mantissa right-aligned and possibly denormal.
REQ-005 SHALL have port din_valid, input, 1: upstream result present.
REQ-006 SHALL have port din_ready, output, 1: block can accept.
REQ-007 SHALL have ports dout_uni_sgn (out, 1), dout_uni_exp (out, 6), dout_uni_man (out, 22): normalized result.
REQ-008 SHALL have ports dout_zero, dout_denorm, dout_ovf, dout_inexact (out, 1 each): result flags.
REQ-009 SHALL have ports dout_valid (out, 1) and dout_ready (in, 1): output handshake.

Function
REQ-010 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-011 In IDLE, din_ready SHALL be 1; in SHIFT and DONE, din_ready SHALL be 0.
REQ-012 Transfer SHALL occur on a rising edge with din_valid=1 and din_ready=1; operands are latched and FSM enters SHIFT; inexact is cleared.
REQ-013 In SHIFT, one evaluation per cycle, in priority order:
  a) man[21]=1 and exp=63: man:=0, exp:=63, ovf:=1, go DONE.
  b) man[21]=1: man:=man>>1, exp:=exp+1, inexact|=dropped bit, stay SHIFT.
  c) man=0: exp:=0, zero:=1, go DONE.
  d) man[NORM_BIT]=1: go DONE.
  e) exp=0: denorm:=1, go DONE.
  f) otherwise: man:=man<<1, exp:=exp-1, stay SHIFT.
REQ-014 Each left or right shift SHALL move exactly 1 bit per cycle; SHIFT residency SHALL therefore be (shift count + 1) cycles, worst case 21.
REQ-015 An input already normalized SHALL produce dout_valid=1 two rising edges after the transfer edge.
REQ-016 In DONE, dout_valid SHALL be 1 and all dout_* SHALL be stable until the edge where dout_ready=1; on that edge FSM SHALL return to IDLE.
REQ-017 dout_valid SHALL be 0 in IDLE and SHIFT; dout_* values outside DONE are don't-care but SHALL not be X after reset.
REQ-018 No new input SHALL be accepted in the edge on which DONE retires (no bypass); din_ready rises the cycle after.
REQ-019 Sign SHALL pass through unchanged, including zero results.
REQ-020 Exponent arithmetic SHALL be 6-bit unsigned; case a) prevents wrap above 63; case e) prevents wrap below 0.

Reset
REQ-021 On rst=1 at a rising edge, FSM SHALL enter IDLE, din_ready=1, dout_valid=0, all dout_* data and flags = 0.
REQ-022 rst SHALL override any in-progress SHIFT or pending DONE; the in-flight operand SHALL be discarded with no output.
REQ-023 rst SHALL take priority over simultaneous din_valid.

Structure
REQ-024 SHALL place EXP_W=6, MAN_W=22, EXP_MAX=63 and the FSM state encoding in shared package fpu_pkg.
REQ-025 SHALL be a single module; no sub-module required (iterative shifter, no leading-zero counter).

Verification
REQ-026 Normalized: exp=10, man=0x100000 -> dout_valid 2 edges after transfer, exp=10, man=0x100000, all flags 0.
REQ-027 Carry: exp=10, man=0x300001 -> exp=11, man=0x180000, inexact=1, 3 edges latency.
REQ-028 Left shift: exp=30, man=0x000001 -> exp=10, man=0x100000, latency 22 edges; denorm case exp=3, man=0x000100 -> exp=0, man=0x000800, denorm=1.
REQ-029 Boundaries: man=0 with any exp -> exp=0, zero=1; exp=63, man=0x200000 -> exp=63, man=0, ovf=1.
REQ-030 Handshake/reset: hold dout_ready=0 10 cycles -> outputs stable, din_ready=0; assert rst mid-SHIFT -> next cycle din_ready=1, dout_valid=0, no output ever produced for that operand.
